// File: rtl/bus_decoder_n.sv
// ---------------------------------------------------------------------------
// bus_decoder_n
//   Routes one bus master to one of NUM_SLV slaves. The slave is chosen by
//   comparing the masked address with each slave's masked base address.
//   Addresses that match no slave get an error response. A watchdog gives
//   up on a slave that never completes and returns an error instead.
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   m_addr/m_wdata  master address and write data, held while m_valid is high
//   m_mode          1 = write, 0 = read
//   m_valid         master request
//   m_rready        master can accept read data
//   m_rdata         read data to the master (zero unless m_rvalid is high)
//   m_wready        write-complete pulse to the master
//   m_rvalid        read data valid to the master
//   m_err           error flag, meaningful in the completion cycle
//   s_addr/s_wdata/s_mode  master address, data and mode broadcast to slaves
//   s_valid         one-hot request to the selected slave
//   s_rready        m_rready routed to the selected slave only
//   s_rdata         packed slave read data, slot i = [i*DATA_W +: DATA_W]
//   s_wready        per-slave write complete
//   s_rvalid        per-slave read valid
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module bus_decoder_n #(
    parameter int                        NUM_SLV  = 4,
    parameter int                        ADDR_W   = 32,
    parameter int                        DATA_W   = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                                     32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {4{32'hF000_0000}},
    parameter int                        TIMEOUT  = 255,
    parameter logic [31:0]               ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           m_addr,
    input  logic [DATA_W-1:0]           m_wdata,
    input  logic                        m_mode,
    input  logic                        m_valid,
    input  logic                        m_rready,
    output logic [DATA_W-1:0]           m_rdata,
    output logic                        m_wready,
    output logic                        m_rvalid,
    output logic                        m_err,
    output logic [ADDR_W-1:0]           s_addr,
    output logic [DATA_W-1:0]           s_wdata,
    output logic                        s_mode,
    output logic [NUM_SLV-1:0]          s_valid,
    output logic [NUM_SLV-1:0]          s_rready,
    input  logic [NUM_SLV*DATA_W-1:0]   s_rdata,
    input  logic [NUM_SLV-1:0]          s_wready,
    input  logic [NUM_SLV-1:0]          s_rvalid
);

    localparam int                SEL_W     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int                WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit                WD_EN     = (TIMEOUT != 0);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_DATA);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [WD_W-1:0]    r_wd_cnt;
    logic [WD_W-1:0]    w_wd_nxt;

    logic               w_hit;
    logic [SEL_W-1:0]   w_idx;
    logic [NUM_SLV-1:0] w_sel_oh;
    logic [DATA_W-1:0]  w_slv_rdata;
    logic               w_slv_wready;
    logic               w_slv_rvalid;
    logic               w_done;

    // The request fields reach every slave unchanged; only s_valid selects.
    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
    assign s_mode  = m_mode;

    // Scanning from the top index down lets the lowest matching index
    // overwrite the others, so overlapping regions resolve to the lowest slot.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
                w_hit = 1'b1;
                w_idx = SEL_W'(i);
            end
        end
    end

    // Responses of the latched slave; all other slaves are masked off here.
    assign w_sel_oh     = NUM_SLV'(1) << r_sel;
    assign w_slv_wready = |(s_wready & w_sel_oh);
    assign w_slv_rvalid = |(s_rvalid & w_sel_oh);

    always_comb begin
        w_slv_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_slv_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_wd_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_wd_cnt <= w_wd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_wd_nxt    = r_wd_cnt;
        w_done      = 1'b0;
        s_valid     = '0;
        s_rready    = '0;
        m_wready    = 1'b0;
        m_rvalid    = 1'b0;
        m_rdata     = '0;
        m_err       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (m_valid) begin
                    if (w_hit) begin
                        w_sel_nxt   = w_idx;
                        w_wd_nxt    = '0;
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end

            ST_ACTIVE: begin
                s_valid  = w_sel_oh;
                s_rready = w_sel_oh & {NUM_SLV{m_rready}};
                if (m_mode) begin
                    m_wready = w_slv_wready;
                    w_done   = w_slv_wready;
                end else begin
                    m_rvalid = w_slv_rvalid;
                    if (w_slv_rvalid) begin
                        m_rdata = w_slv_rdata;
                    end
                    w_done = w_slv_rvalid & m_rready;
                end
                // Completion takes priority over an expiring watchdog.
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (WD_EN) begin
                    if (r_wd_cnt == WD_LAST) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_wd_nxt = r_wd_cnt + WD_W'(1);
                    end
                end
            end

            ST_ERR: begin
                m_err = 1'b1;
                if (m_mode) begin
                    m_wready    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    m_rvalid = 1'b1;
                    m_rdata  = ERR_RDATA;
                    if (m_rready) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Nothing may be presented to either side while reset is asserted,
        // even if the registered state still shows a transaction in flight.
        if (rst) begin
            s_valid  = '0;
            s_rready = '0;
            m_wready = 1'b0;
            m_rvalid = 1'b0;
            m_rdata  = '0;
            m_err    = 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_decoder_n.sv
`timescale 1ns/1ps
module tb_bus_decoder_n;

    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [31:0]  m_addr, m_wdata, m_rdata, s_addr, s_wdata;
    logic         m_mode, m_valid, m_rready, m_wready, m_rvalid, m_err, s_mode;
    logic [3:0]   s_valid, s_rready, s_wready, s_rvalid;
    logic [127:0] s_rdata;

    // Second instance: two slaves whose regions overlap completely.
    logic [31:0]  ovl_m_rdata, ovl_s_addr, ovl_s_wdata;
    logic         ovl_m_wready, ovl_m_rvalid, ovl_m_err, ovl_s_mode;
    logic [1:0]   ovl_s_valid, ovl_s_rready;
    logic [63:0]  ovl_s_rdata  = {32'h1111_1111, 32'h0000_0A0A};
    logic [1:0]   ovl_s_wready = 2'b11;
    logic [1:0]   ovl_s_rvalid = 2'b11;

    bus_decoder_n #(
        .NUM_SLV (4), .ADDR_W (32), .DATA_W (32),
        .SLV_BASE({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK({32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT (TO), .ERR_DATA(ERRD)
    ) u_dut (
        .clk(clk), .rst(rst), .m_addr(m_addr), .m_wdata(m_wdata), .m_mode(m_mode),
        .m_valid(m_valid), .m_rready(m_rready), .m_rdata(m_rdata), .m_wready(m_wready),
        .m_rvalid(m_rvalid), .m_err(m_err), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_mode(s_mode), .s_valid(s_valid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_wready(s_wready), .s_rvalid(s_rvalid)
    );

    bus_decoder_n #(
        .NUM_SLV (2), .ADDR_W (32), .DATA_W (32),
        .SLV_BASE(64'h0), .SLV_MASK(64'h0), .TIMEOUT (0), .ERR_DATA(ERRD)
    ) u_ovl (
        .clk(clk), .rst(rst), .m_addr(m_addr), .m_wdata(m_wdata), .m_mode(m_mode),
        .m_valid(m_valid), .m_rready(m_rready), .m_rdata(ovl_m_rdata),
        .m_wready(ovl_m_wready), .m_rvalid(ovl_m_rvalid), .m_err(ovl_m_err),
        .s_addr(ovl_s_addr), .s_wdata(ovl_s_wdata), .s_mode(ovl_s_mode),
        .s_valid(ovl_s_valid), .s_rready(ovl_s_rready), .s_rdata(ovl_s_rdata),
        .s_wready(ovl_s_wready), .s_rvalid(ovl_s_rvalid)
    );

    // Address map of the main instance.
    logic [31:0] BASE [0:3] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    logic [31:0] MASK [0:3] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000};

    // Expected outputs for the current cycle.
    logic [3:0]  exp_sv, exp_srr;
    logic        exp_wr, exp_rv, exp_err, sv_chk;
    logic [31:0] exp_rd;

    int checks = 0, failures = 0;
    int cnt_sv = 0, cnt_wr = 0, cnt_rv = 0, cnt_ovl = 0;
    int b_sv, b_wr, b_rv;

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & MASK[i]) == (BASE[i] & MASK[i])) return i;
        return -1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic compare();
        if (sv_chk) begin
            check("s_valid",  32'(s_valid),  32'(exp_sv));
            check("s_rready", 32'(s_rready), 32'(exp_srr));
        end
        check("m_wready", 32'(m_wready), 32'(exp_wr));
        check("m_rvalid", 32'(m_rvalid), 32'(exp_rv));
        check("m_rdata",  m_rdata,       exp_rd);
        check("m_err",    32'(m_err),    32'(exp_err));
        check("s_addr",   s_addr,        m_addr);
        check("s_wdata",  s_wdata,       m_wdata);
        check("s_mode",   32'(s_mode),   32'(m_mode));
        check("ovl_s_valid1", 32'(ovl_s_valid[1]), 32'd0);
        if (ovl_m_rvalid) check("ovl_m_rdata", ovl_m_rdata, 32'h0000_0A0A);
        if (s_valid != 4'd0) cnt_sv++;
        if (m_wready) cnt_wr++;
        if (m_rvalid) cnt_rv++;
        if (ovl_s_valid[0]) cnt_ovl++;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_sv = '0; exp_srr = '0; exp_wr = 1'b0; exp_rv = 1'b0;
        exp_rd = '0; exp_err = 1'b0; sv_chk = 1'b1;
    endtask

    // Slave j (if any) answers with rd when resp is set; the rest send noise.
    task automatic drive_slaves(input int j, input bit resp, input bit mode, input logic [31:0] rd);
        for (int i = 0; i < 4; i++) begin
            if (i == j) begin
                s_wready[i] = resp & mode;
                s_rvalid[i] = resp & ~mode;
                s_rdata[i*32 +: 32] = resp ? rd : $urandom;
            end else begin
                s_wready[i] = 1'($urandom_range(0, 1));
                s_rvalid[i] = 1'($urandom_range(0, 1));
                s_rdata[i*32 +: 32] = $urandom;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            m_valid = 1'b0; m_addr = $urandom; m_wdata = $urandom;
            m_mode = 1'($urandom_range(0, 1)); m_rready = 1'($urandom_range(0, 1));
            drive_slaves(-1, 1'b0, 1'b0, 32'h0);
            set_idle_exp();
            cycle();
        end
    endtask

    function automatic bit pick_rr(input int hold, input int n);
        if (hold < 0) return 1'($urandom_range(0, 1));
        return (n >= hold);
    endfunction

    // One transaction. The slave responds from its L-th request cycle on;
    // rr_hold < 0 means random m_rready, otherwise m_rready rises rr_hold
    // cycles after data is available.
    task automatic run_txn(input logic [31:0] addr, input bit mode, input logic [31:0] wd,
                           input logic [31:0] rd, input int L, input int rr_hold);
        int  j;
        bit  to_err, done, resp, rr;
        j = model_decode(addr);
        m_addr = addr; m_wdata = wd; m_mode = mode; m_valid = 1'b1;
        m_rready = 1'($urandom_range(0, 1));
        drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        set_idle_exp();
        cycle();
        to_err = (j < 0);
        done   = 1'b0;
        for (int a = 0; j >= 0 && !done && !to_err; a++) begin
            resp = (a >= L);
            rr   = resp ? pick_rr(rr_hold, a - L) : 1'($urandom_range(0, 1));
            m_rready = rr;
            drive_slaves(j, resp, mode, rd);
            set_idle_exp();
            exp_sv  = 4'(1 << j);
            exp_srr = rr ? 4'(1 << j) : 4'd0;
            exp_wr  = mode & resp;
            exp_rv  = ~mode & resp;
            exp_rd  = (~mode & resp) ? rd : 32'h0;
            cycle();
            if (mode ? resp : (resp && rr)) done = 1'b1;
            else if (a == TO - 1) to_err = 1'b1;
        end
        for (int e = 0; to_err && e < 64; e++) begin
            rr = pick_rr(rr_hold, e);
            m_rready = rr;
            drive_slaves(-1, 1'b0, 1'b0, 32'h0);
            set_idle_exp();
            exp_wr  = mode;
            exp_rv  = ~mode;
            exp_rd  = mode ? 32'h0 : ERRD;
            exp_err = 1'b1;
            cycle();
            if (mode || rr) break;
        end
        m_valid = 1'b0;
    endtask

    task automatic snap();
        b_sv = cnt_sv; b_wr = cnt_wr; b_rv = cnt_rv;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0]  nib;
        logic [31:0] lo;
        int          r;
        rst = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_mode = 1'b0;
        m_rready = 1'b0; s_wready = '0; s_rvalid = '0; s_rdata = '0;
        set_idle_exp();
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) cycle();
        rst = 1'b0;

        // Pin the reference decoder against hand-derived regions.
        check("dec_1000_0004", 32'(model_decode(32'h1000_0004)), 32'd1);
        check("dec_2000_0010", 32'(model_decode(32'h2000_0010)), 32'd2);
        check("dec_3000_ABCD", 32'(model_decode(32'h3000_ABCD)), 32'd3);
        check("dec_0000_0100", 32'(model_decode(32'h0000_0100)), 32'd0);
        check("dec_3001_0000", 32'(model_decode(32'h3001_0000)), 32'hFFFF_FFFF);
        check("dec_8000_0000", 32'(model_decode(32'h8000_0000)), 32'hFFFF_FFFF);
        idle(2);

        // Write to slave1, response three cycles after the request.
        snap();
        run_txn(32'h1000_0004, 1'b1, 32'hA5A5_A5A5, 32'h0, 3, -1);
        check("wr_sv_cycles", 32'(cnt_sv - b_sv), 32'd4);
        check("wr_pulses",    32'(cnt_wr - b_wr), 32'd1);
        idle(1);

        // Read from slave2, master stalls two cycles.
        snap();
        run_txn(32'h2000_0010, 1'b0, 32'h0, 32'h1234_5678, 0, 2);
        check("rd_rvalid_cycles", 32'(cnt_rv - b_rv), 32'd3);
        check("rd_sv_cycles",     32'(cnt_sv - b_sv), 32'd3);
        idle(1);

        // Unmapped read, then unmapped write.
        snap();
        run_txn(32'h3001_0000, 1'b0, 32'h0, 32'h0, 0, 1);
        check("unm_rd_sv",     32'(cnt_sv - b_sv), 32'd0);
        check("unm_rd_rvalid", 32'(cnt_rv - b_rv), 32'd2);
        snap();
        run_txn(32'h3001_0000, 1'b1, 32'h5555_0000, 32'h0, 0, -1);
        check("unm_wr_pulses", 32'(cnt_wr - b_wr), 32'd1);
        check("unm_wr_sv",     32'(cnt_sv - b_sv), 32'd0);

        // Slave0 never answers: watchdog abort, then a late wready is ignored.
        snap();
        run_txn(32'h0000_0100, 1'b1, 32'h0BAD_F00D, 32'h0, 1000, -1);
        check("to_sv_cycles", 32'(cnt_sv - b_sv), 32'd8);
        check("to_err_pulse", 32'(cnt_wr - b_wr), 32'd1);
        for (int k = 0; k < 3; k++) begin
            m_valid = 1'b0;
            drive_slaves(-1, 1'b0, 1'b0, 32'h0);
            s_wready = 4'b0001;
            set_idle_exp();
            cycle();
        end

        // Reset in the second request cycle of a read.
        m_addr = 32'h2000_0010; m_mode = 1'b0; m_valid = 1'b1; m_rready = 1'b0;
        drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        set_idle_exp();
        cycle();
        drive_slaves(2, 1'b0, 1'b0, 32'h0);
        set_idle_exp();
        exp_sv = 4'b0100;
        cycle();
        rst = 1'b1; m_rready = 1'b1;
        drive_slaves(2, 1'b1, 1'b0, 32'hCAFE_0001);
        set_idle_exp();
        sv_chk = 1'b0;
        cycle();
        rst = 1'b0; m_valid = 1'b0;
        drive_slaves(2, 1'b1, 1'b0, 32'hCAFE_0001);
        set_idle_exp();
        cycle();
        snap();
        run_txn(32'h2000_0020, 1'b0, 32'h0, 32'h7777_8888, 1, 0);
        check("post_rst_rvalid", 32'(cnt_rv - b_rv), 32'd1);
        idle(1);

        // Randomized traffic, including back-to-back requests.
        for (int t = 0; t < 150; t++) begin
            nib = 4'($urandom_range(0, 7));
            lo  = $urandom;
            if (nib == 4'd3 && $urandom_range(0, 1) == 1) lo[27:16] = 12'h000;
            r = $urandom_range(0, 3);
            run_txn({nib, lo[27:0]}, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    $urandom_range(0, 10), (r == 3) ? -1 : r);
            idle($urandom_range(0, 2));
        end

        check("ovl_slave0_used", 32'(cnt_ovl > 0), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
